// File: rtl/arm_multicycle_controller_if.sv
// Control/status bundle between the multicycle controller and the ARM datapath.
// The controller side is the master. The datapath/IR side is the slave.
interface arm_multicycle_controller_if;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [1:0] FlagWrite;
    logic [3:0] flags;

    modport master (
        input  cond, op, funct, rd, alu_flags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
               ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc, FlagWrite, flags
    );

    modport slave (
        output cond, op, funct, rd, alu_flags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA,
               ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc, FlagWrite, flags
    );
endinterface

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM sequencer: FSM over fetch/decode/execute/memory/writeback,
// NZCV flag register and condition-code evaluation gating architectural writes.
module arm_multicycle_controller (
    input  logic                          clk,
    input  logic                          reset,
    arm_multicycle_controller_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t     state_r, next_state_s;
    logic [3:0] flags_r;

    logic       dp_known_s, dp_cmp_s;
    logic [1:0] dp_alu_s, dp_fw_s;

    logic       pcw_s, adr_s, mw_s, irw_s, rw_s, asa_s;
    logic [1:0] rs_s, asb_s, alc_s, fw_s;

    function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: cond_check = z;
            4'b0001: cond_check = ~z;
            4'b0010: cond_check = cy;
            4'b0011: cond_check = ~cy;
            4'b0100: cond_check = n;
            4'b0101: cond_check = ~n;
            4'b0110: cond_check = v;
            4'b0111: cond_check = ~v;
            4'b1000: cond_check = cy & ~z;
            4'b1001: cond_check = ~cy | z;
            4'b1010: cond_check = (n == v);
            4'b1011: cond_check = (n != v);
            4'b1100: cond_check = ~z & (n == v);
            4'b1101: cond_check = z | (n != v);
            4'b1110: cond_check = 1'b1;
            4'b1111: cond_check = 1'b0;
            default: cond_check = 1'b0;
        endcase
    endfunction

    // Data-processing command decode: ALU op, flag-write enables, CMP/NOP detection.
    always_comb begin
        dp_known_s = 1'b1;
        dp_cmp_s   = 1'b0;
        dp_alu_s   = 2'b00;
        dp_fw_s    = 2'b00;
        case (bus.funct[4:1])
            4'b0100: begin dp_alu_s = 2'b00; dp_fw_s = {bus.funct[0], bus.funct[0]}; end
            4'b0010: begin dp_alu_s = 2'b01; dp_fw_s = {bus.funct[0], bus.funct[0]}; end
            4'b0000: begin dp_alu_s = 2'b10; dp_fw_s = {bus.funct[0], 1'b0}; end
            4'b1100: begin dp_alu_s = 2'b11; dp_fw_s = {bus.funct[0], 1'b0}; end
            4'b1010: begin dp_alu_s = 2'b01; dp_fw_s = 2'b11; dp_cmp_s = 1'b1; end
            default: dp_known_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= S_FETCH;
        else       state_r <= next_state_s;
    end

    // Next-state logic and Moore control outputs.
    always_comb begin
        next_state_s = S_FETCH;
        pcw_s = 1'b0; adr_s = 1'b0; mw_s = 1'b0; irw_s = 1'b0; rw_s = 1'b0; asa_s = 1'b0;
        rs_s  = 2'b00; asb_s = 2'b00; alc_s = 2'b00; fw_s = 2'b00;
        case (state_r)
            S_FETCH: begin
                irw_s = 1'b1; pcw_s = 1'b1; asa_s = 1'b1; asb_s = 2'b10; rs_s = 2'b10;
                next_state_s = S_DECODE;
            end
            S_DECODE: begin
                asa_s = 1'b1; asb_s = 2'b10; rs_s = 2'b10;
                if (!cond_check(bus.cond, flags_r)) next_state_s = S_FETCH;
                else begin
                    case (bus.op)
                        2'b01:   next_state_s = S_MEMADR;
                        2'b00:   next_state_s = bus.funct[5] ? S_EXECI : S_EXECR;
                        2'b10:   next_state_s = S_BRANCH;
                        default: next_state_s = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                asb_s = 2'b01;
                next_state_s = bus.funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_s = 1'b1; rs_s = 2'b00;
                next_state_s = S_MEMWB;
            end
            S_MEMWB: begin
                rs_s = 2'b01; rw_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEMWR: begin
                adr_s = 1'b1; mw_s = 1'b1;
                next_state_s = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                asb_s = (state_r == S_EXECI) ? 2'b01 : 2'b00;
                if (dp_known_s) begin
                    alc_s = dp_alu_s;
                    fw_s  = dp_fw_s;
                    next_state_s = dp_cmp_s ? S_FETCH : S_ALUWB;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_ALUWB: begin
                rs_s = 2'b00; rw_s = 1'b1;
                pcw_s = (bus.rd == 4'd15);
                next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                asb_s = 2'b01; rs_s = 2'b10; pcw_s = 1'b1;
                next_state_s = S_FETCH;
            end
            default: next_state_s = S_FETCH;
        endcase
    end

    // NZCV register: each half captures the ALU flags only when its enable is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else begin
            if (fw_s[1]) flags_r[3:2] <= bus.alu_flags[3:2];
            if (fw_s[0]) flags_r[1:0] <= bus.alu_flags[1:0];
        end
    end

    // Drive the bus; reset kills every write strobe in the same cycle.
    always_comb begin
        bus.PCWrite    = pcw_s & ~reset;
        bus.IRWrite    = irw_s & ~reset;
        bus.MemWrite   = mw_s  & ~reset;
        bus.RegWrite   = rw_s  & ~reset;
        bus.FlagWrite  = reset ? 2'b00 : fw_s;
        bus.AdrSrc     = adr_s;
        bus.ALUSrcA    = asa_s;
        bus.ResultSrc  = rs_s;
        bus.ALUSrcB    = asb_s;
        bus.ALUControl = alc_s;
        bus.ImmSrc     = bus.op;
        bus.RegSrc     = {(bus.op == 2'b01) & ~bus.funct[0], (bus.op == 2'b10)};
        bus.flags      = flags_r;
    end

endmodule
